// File: rtl/ysyx_25040111_idu_sched.sv
// Decode-stage scheduler: buffers one fetched instruction, classifies it,
// and issues it to EXU once the register scoreboard shows no RAW/WAW hazard.
module ysyx_25040111_idu_sched #(
  parameter int unsigned NREG  = 32,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [31:0]      in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_inst,
  output logic [31:0]      out_pc,
  output logic [3:0]       out_cls,
  output logic             out_chos,
  output logic             out_illegal,
  input  logic             wb_valid,
  input  logic [4:0]       wb_rd,
  input  logic             flush,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int unsigned CLS_W = 4;
  localparam int unsigned REG_W = 5;

  localparam logic [CLS_W-1:0] CLS_ILL    = CLS_W'(0);
  localparam logic [CLS_W-1:0] CLS_LUI    = CLS_W'(1);
  localparam logic [CLS_W-1:0] CLS_AUIPC  = CLS_W'(2);
  localparam logic [CLS_W-1:0] CLS_JAL    = CLS_W'(3);
  localparam logic [CLS_W-1:0] CLS_JALR   = CLS_W'(4);
  localparam logic [CLS_W-1:0] CLS_BRANCH = CLS_W'(5);
  localparam logic [CLS_W-1:0] CLS_LOAD   = CLS_W'(6);
  localparam logic [CLS_W-1:0] CLS_STORE  = CLS_W'(7);
  localparam logic [CLS_W-1:0] CLS_OPIMM  = CLS_W'(8);
  localparam logic [CLS_W-1:0] CLS_OP     = CLS_W'(9);
  localparam logic [CLS_W-1:0] CLS_SYSTEM = CLS_W'(10);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_VALID = 2'd1,
    S_STALL = 2'd2
  } state_t;

  // Opcode to class code
  function automatic logic [CLS_W-1:0] decode_cls(input logic [6:0] op);
    logic [CLS_W-1:0] c;
    case (op)
      7'b0110111: c = CLS_LUI;
      7'b0010111: c = CLS_AUIPC;
      7'b1101111: c = CLS_JAL;
      7'b1100111: c = CLS_JALR;
      7'b1100011: c = CLS_BRANCH;
      7'b0000011: c = CLS_LOAD;
      7'b0100011: c = CLS_STORE;
      7'b0010011: c = CLS_OPIMM;
      7'b0110011: c = CLS_OP;
      7'b1110011: c = CLS_SYSTEM;
      default:    c = CLS_ILL;
    endcase
    return c;
  endfunction

  function automatic logic uses_rs1(input logic [CLS_W-1:0] c);
    return (c == CLS_JALR) || (c == CLS_BRANCH) || (c == CLS_LOAD) ||
           (c == CLS_STORE) || (c == CLS_OPIMM) || (c == CLS_OP);
  endfunction

  function automatic logic uses_rs2(input logic [CLS_W-1:0] c);
    return (c == CLS_BRANCH) || (c == CLS_STORE) || (c == CLS_OP);
  endfunction

  function automatic logic writes_rd(input logic [CLS_W-1:0] c);
    return (c == CLS_LUI) || (c == CLS_AUIPC) || (c == CLS_JAL) ||
           (c == CLS_JALR) || (c == CLS_LOAD) || (c == CLS_OPIMM) ||
           (c == CLS_OP) || (c == CLS_SYSTEM);
  endfunction

  // True when reg index r is nonzero, tracked, and marked busy in sb
  function automatic logic reg_busy(input logic [REG_W-1:0] r,
                                    input logic [NREG-1:0]  sb);
    logic b;
    b = 1'b0;
    for (int unsigned i = 1; i < NREG; i++) begin
      if (32'(r) == i) b = sb[i];
    end
    return b;
  endfunction

  // RAW/WAW hazard of an instruction against a scoreboard snapshot
  function automatic logic hazard(input logic [31:0]      inst,
                                  input logic [CLS_W-1:0] c,
                                  input logic [NREG-1:0]  sb);
    return (uses_rs1(c)  && reg_busy(inst[19:15], sb)) ||
           (uses_rs2(c)  && reg_busy(inst[24:20], sb)) ||
           (writes_rd(c) && reg_busy(inst[11:7],  sb));
  endfunction

  state_t           state_q;
  state_t           state_d;
  logic [NREG-1:0]  busy;
  logic [NREG-1:0]  busy_next;
  logic [CLS_W-1:0] in_cls;
  logic             accept;
  logic             issue;
  logic             hz_new;
  logic             hz_buf;

  // Handshake: flush blocks both directions for the cycle
  assign out_valid = (state_q == S_VALID) && !flush;
  assign in_ready  = !flush && ((state_q == S_EMPTY) ||
                                ((state_q == S_VALID) && out_ready));
  assign accept    = in_valid && in_ready;
  assign issue     = out_valid && out_ready;
  assign in_cls    = decode_cls(in_inst[6:0]);

  // Scoreboard update: retire clears, issue of an rd-writer sets (set wins)
  always_comb begin
    busy_next = busy;
    for (int unsigned i = 1; i < NREG; i++) begin
      if (wb_valid && (32'(wb_rd) == i)) busy_next[i] = 1'b0;
      if (issue && writes_rd(out_cls) && (32'(out_inst[11:7]) == i))
        busy_next[i] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  // Hazards are judged against the scoreboard as it will stand next cycle
  assign hz_new = hazard(in_inst,  in_cls,  busy_next);
  assign hz_buf = hazard(out_inst, out_cls, busy_next);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_EMPTY;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_EMPTY;
    end else begin
      case (state_q)
        S_EMPTY: if (accept) state_d = hz_new ? S_STALL : S_VALID;
        S_VALID: begin
          if (issue) begin
            if (accept) state_d = hz_new ? S_STALL : S_VALID;
            else        state_d = S_EMPTY;
          end
        end
        S_STALL: if (!hz_buf) state_d = S_VALID;
        default: state_d = S_EMPTY;
      endcase
    end
  end

  // Pipeline register, decoded at accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_inst    <= 32'd0;
      out_pc      <= 32'd0;
      out_cls     <= CLS_ILL;
      out_chos    <= 1'b0;
      out_illegal <= 1'b1;
    end else if (accept) begin
      out_inst    <= in_inst;
      out_pc      <= in_pc;
      out_cls     <= in_cls;
      out_chos    <= (in_cls == CLS_LUI);
      out_illegal <= (in_cls == CLS_ILL);
    end
  end

  // Scoreboard register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_next;
  end

  // Saturating count of cycles spent stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  stall_cnt <= '0;
    else if (state_q == S_STALL && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_ysyx_25040111_idu_sched.sv
// Directed self-checking bench for the decode-stage scheduler.
module tb_ysyx_25040111_idu_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [31:0] in_inst, in_pc;
  logic        out_valid, out_ready;
  logic [31:0] out_inst, out_pc;
  logic [3:0]  out_cls;
  logic        out_chos, out_illegal;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        flush;
  logic [31:0] stall_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [31:0] I_LUI5   = 32'h123452B7; // lui x5
  localparam logic [31:0] I_AUIPC6 = 32'h00000317; // auipc x6,0
  localparam logic [31:0] I_ADD761 = 32'h001303B3; // add x7,x6,x1
  localparam logic [31:0] I_ADDI11 = 32'h00100593; // addi x11,x0,1
  localparam logic [31:0] I_ADDI12 = 32'h00200613; // addi x12,x0,2
  localparam logic [31:0] I_ADDI13 = 32'h00000693; // addi x13,x0,0
  localparam logic [31:0] I_ADD14  = 32'h00068733; // add x14,x13,x0
  localparam logic [31:0] I_NOP    = 32'h00000013;
  localparam logic [31:0] I_ILL    = 32'h0000007F;
  localparam logic [31:0] I_LUI0   = 32'h00001037; // lui x0,1
  localparam logic [31:0] I_ADD100 = 32'h000000B3; // add x1,x0,x0
  localparam logic [31:0] I_ADDI15 = 32'h00000793; // addi x15,x0,0

  ysyx_25040111_idu_sched #(.NREG(32), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_pc(out_pc), .out_cls(out_cls), .out_chos(out_chos),
    .out_illegal(out_illegal), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .flush(flush), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Advance past the next rising edge; inputs are driven afterwards
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic retire(input logic [4:0] r);
    wb_valid = 1'b1; wb_rd = r;
    step();
    wb_valid = 1'b0; wb_rd = 5'd0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_inst = 32'd0; in_pc = 32'd0;
    out_ready = 1'b0; wb_valid = 1'b0; wb_rd = 5'd0; flush = 1'b0;
    #12;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b exp 0", out_valid); end
    n_tests++; if (out_illegal !== 1'b1) begin n_fail++; $display("FAIL reset_out_illegal: got %b exp 1", out_illegal); end
    n_tests++; if ({out_inst, out_pc, out_cls, out_chos} !== 69'd0) begin n_fail++; $display("FAIL reset_out_data: got %h %h %h %b exp 0", out_inst, out_pc, out_cls, out_chos); end
    n_tests++; if (stall_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_stall_cnt: got %0d exp 0", stall_cnt); end
    @(negedge clk); rst_n = 1'b1;
    step();
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b exp 1", in_ready); end
  endtask

  task automatic test_lui();
    out_ready = 1'b1;
    in_valid = 1'b1; in_inst = I_LUI5; in_pc = 32'h100;
    step();
    in_valid = 1'b0; #1;
    n_tests++; if ({out_valid, out_cls, out_chos, out_illegal} !== {1'b1, 4'd1, 1'b1, 1'b0}) begin n_fail++; $display("FAIL lui_decode: got v=%b cls=%0d chos=%b ill=%b exp v=1 cls=1 chos=1 ill=0", out_valid, out_cls, out_chos, out_illegal); end
    n_tests++; if (out_inst !== I_LUI5 || out_pc !== 32'h100) begin n_fail++; $display("FAIL lui_data: got %h %h exp %h 00000100", out_inst, out_pc, I_LUI5); end
    step();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL lui_drain: got %b exp 0", out_valid); end
    n_tests++; if (dut.busy[5] !== 1'b1) begin n_fail++; $display("FAIL lui_busy5: got %b exp 1", dut.busy[5]); end
    retire(5'd5);
    n_tests++; if (dut.busy[5] !== 1'b0) begin n_fail++; $display("FAIL lui_busy5_clear: got %b exp 0", dut.busy[5]); end
  endtask

  task automatic test_stall();
    in_valid = 1'b1; in_inst = I_AUIPC6; in_pc = 32'h80000000;
    step();
    in_inst = I_ADD761; in_pc = 32'h80000004; #1;
    n_tests++; if ({out_valid, out_cls, out_chos} !== {1'b1, 4'd2, 1'b0}) begin n_fail++; $display("FAIL auipc_decode: got v=%b cls=%0d chos=%b exp v=1 cls=2 chos=0", out_valid, out_cls, out_chos); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL auipc_in_ready: got %b exp 1", in_ready); end
    step();
    in_valid = 1'b0; #1;
    n_tests++; if (out_valid !== 1'b0 || out_cls !== 4'd9 || out_pc !== 32'h80000004) begin n_fail++; $display("FAIL add_stall_enter: got v=%b cls=%0d pc=%h exp v=0 cls=9 pc=80000004", out_valid, out_cls, out_pc); end
    n_tests++; if (stall_cnt !== 32'd0) begin n_fail++; $display("FAIL stall_cnt_0: got %0d exp 0", stall_cnt); end
    step(); step();
    n_tests++; if (stall_cnt !== 32'd2) begin n_fail++; $display("FAIL stall_cnt_2: got %0d exp 2", stall_cnt); end
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready: got %b exp 0", in_ready); end
    wb_valid = 1'b1; wb_rd = 5'd6; #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL no_bypass: got %b exp 0", out_valid); end
    step();
    wb_valid = 1'b0; wb_rd = 5'd0; #1;
    n_tests++; if (out_valid !== 1'b1 || out_inst !== I_ADD761) begin n_fail++; $display("FAIL add_unblock: got v=%b inst=%h exp v=1 inst=%h", out_valid, out_inst, I_ADD761); end
    n_tests++; if (dut.busy[6] !== 1'b0) begin n_fail++; $display("FAIL busy6_clear: got %b exp 0", dut.busy[6]); end
    n_tests++; if (stall_cnt !== 32'd3) begin n_fail++; $display("FAIL stall_cnt_3: got %0d exp 3", stall_cnt); end
    step();
    n_tests++; if (out_valid !== 1'b0 || dut.busy[7] !== 1'b1) begin n_fail++; $display("FAIL add_issue: got v=%b busy7=%b exp v=0 busy7=1", out_valid, dut.busy[7]); end
    retire(5'd7);
  endtask

  task automatic test_back_to_back();
    logic [31:0] inst [10];
    int issues = 0;
    int ready_lo = 0;
    for (int k = 1; k <= 10; k++) inst[k-1] = (32'(k) << 20) | (32'(k) << 7) | 32'h13;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_inst = inst[i]; in_pc = 32'h1000 + 32'(4 * i); #1;
      if (in_ready !== 1'b1) ready_lo++;
      if (i > 0) begin
        if (out_valid === 1'b1 && out_inst === inst[i-1]) issues++;
      end
      step();
    end
    in_valid = 1'b0; #1;
    if (out_valid === 1'b1 && out_inst === inst[9]) issues++;
    n_tests++; if (issues !== 10) begin n_fail++; $display("FAIL b2b_issues: got %0d exp 10", issues); end
    n_tests++; if (ready_lo !== 0) begin n_fail++; $display("FAIL b2b_in_ready: got %0d low cycles exp 0", ready_lo); end
    step();
    n_tests++; if (out_valid !== 1'b0 || dut.busy !== 32'h000007FE) begin n_fail++; $display("FAIL b2b_drain: got v=%b busy=%h exp v=0 busy=000007fe", out_valid, dut.busy); end
    for (int k = 1; k <= 10; k++) retire(5'(k));
  endtask

  task automatic test_backpressure();
    int bad = 0;
    out_ready = 1'b0;
    in_valid = 1'b1; in_inst = I_ADDI11; in_pc = 32'h200;
    step();
    in_inst = I_ADDI12; in_pc = 32'h204;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_inst !== I_ADDI11 || out_pc !== 32'h200) bad++;
      step();
    end
    n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL bp_hold: got %0d bad cycles exp 0", bad); end
    out_ready = 1'b1; #1;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b exp 1", in_ready); end
    step();
    in_valid = 1'b0; #1;
    n_tests++; if (out_valid !== 1'b1 || out_inst !== I_ADDI12 || out_pc !== 32'h204) begin n_fail++; $display("FAIL bp_same_cycle_accept: got v=%b inst=%h pc=%h exp v=1 inst=%h pc=00000204", out_valid, out_inst, out_pc, I_ADDI12); end
    step();
    retire(5'd11); retire(5'd12);
  endtask

  task automatic test_flush();
    in_valid = 1'b1; in_inst = I_ADDI13; in_pc = 32'h300;
    step();
    in_inst = I_ADD14; in_pc = 32'h304;
    step();
    in_valid = 1'b1; in_inst = I_NOP; in_pc = 32'h308; flush = 1'b1; #1;
    n_tests++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_cycle: got rdy=%b v=%b exp 0 0", in_ready, out_valid); end
    step();
    flush = 1'b0; in_valid = 1'b0; #1;
    n_tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_empty: got v=%b rdy=%b exp v=0 rdy=1", out_valid, in_ready); end
    n_tests++; if (dut.busy[13] !== 1'b1) begin n_fail++; $display("FAIL flush_busy_kept: got %b exp 1", dut.busy[13]); end
    n_tests++; if (stall_cnt !== 32'd4) begin n_fail++; $display("FAIL flush_stall_cnt: got %0d exp 4", stall_cnt); end
    step();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_not_accepted: got %b exp 0", out_valid); end
    retire(5'd13);
  endtask

  task automatic test_illegal_x0();
    in_valid = 1'b1; in_inst = I_ILL; in_pc = 32'h400;
    step();
    in_inst = I_LUI0; in_pc = 32'h404; #1;
    n_tests++; if ({out_valid, out_illegal, out_cls, out_chos} !== {1'b1, 1'b1, 4'd0, 1'b0}) begin n_fail++; $display("FAIL ill_decode: got v=%b ill=%b cls=%0d chos=%b exp v=1 ill=1 cls=0 chos=0", out_valid, out_illegal, out_cls, out_chos); end
    step();
    in_inst = I_ADD100; in_pc = 32'h408; #1;
    n_tests++; if ({out_valid, out_cls, out_chos, out_illegal} !== {1'b1, 4'd1, 1'b1, 1'b0}) begin n_fail++; $display("FAIL lui0_decode: got v=%b cls=%0d chos=%b ill=%b exp v=1 cls=1 chos=1 ill=0", out_valid, out_cls, out_chos, out_illegal); end
    step();
    in_valid = 1'b0; #1;
    n_tests++; if (dut.busy !== 32'd0) begin n_fail++; $display("FAIL x0_never_busy: got %h exp 0", dut.busy); end
    n_tests++; if (out_valid !== 1'b1 || out_inst !== I_ADD100) begin n_fail++; $display("FAIL add_x0_no_stall: got v=%b inst=%h exp v=1 inst=%h", out_valid, out_inst, I_ADD100); end
    step();
    retire(5'd1);
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b1; in_inst = I_ADDI15; in_pc = 32'h500;
    step();
    in_inst = I_NOP; in_pc = 32'h504;
    step();
    in_valid = 1'b0;
    rst_n = 1'b0; #1;
    n_tests++; if (out_valid !== 1'b0 || dut.busy !== 32'd0 || stall_cnt !== 32'd0 || out_illegal !== 1'b1) begin n_fail++; $display("FAIL reset_mid: got v=%b busy=%h cnt=%0d ill=%b exp v=0 busy=0 cnt=0 ill=1", out_valid, dut.busy, stall_cnt, out_illegal); end
    @(negedge clk); rst_n = 1'b1;
    step();
    n_tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mid_release: got rdy=%b v=%b exp rdy=1 v=0", in_ready, out_valid); end
  endtask

  initial begin
    test_reset();
    test_lui();
    test_stall();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_illegal_x0();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
